// File: rtl/icache_axi_pkg.sv
// Shared types and AXI constants for the ICache refill read bridge.
// State encoding and burst/response codes used by bridge and assembler.
package icache_axi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_RET
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] BURST_WRAP = 2'b10;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [2:0] SIZE_4B    = 3'b010;

   localparam logic [7:0] LINE_LEN = 8'd3;
   localparam logic [7:0] UNC_LEN  = 8'd0;

endpackage

// File: rtl/icache_line_assembler.sv
// Collects 32-bit R beats into a 128-bit line buffer.
// Beat counter, lane rotation and sticky error flag; beats past 4 are dropped.
module icache_line_assembler
   import icache_axi_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic [1:0]   start_lane,
   input  logic         beat,
   input  logic [31:0]  rdata,
   input  logic [1:0]   rresp,
   output logic [127:0] line,
   output logic         err
);

   logic [2:0]   cnt_q, cnt_d;
   logic [1:0]   lane0_q, lane0_d;
   logic [127:0] buf_q, buf_d;
   logic         err_q, err_d;
   logic [1:0]   lane;

   assign lane = lane0_q + cnt_q[1:0];
   assign line = buf_q;
   assign err  = err_q;

   // next-state: clear on new request, otherwise fold in one beat
   always_comb begin
      cnt_d   = cnt_q;
      lane0_d = lane0_q;
      buf_d   = buf_q;
      err_d   = err_q;
      if (clr) begin
         cnt_d   = 3'd0;
         lane0_d = start_lane;
         buf_d   = '0;
         err_d   = 1'b0;
      end else if (beat) begin
         err_d = err_q | (rresp != RESP_OKAY);
         if (cnt_q < 3'd4) begin
            buf_d[{lane, 5'd0} +: 32] = rdata;
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   // buffer, counter and error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= 3'd0;
         lane0_q <= 2'd0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         lane0_q <= lane0_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: rtl/icache_axi_rd_bridge.sv
// ICache refill request to single AXI4 read burst, line returned on ret_valid.
// Optional ICACHE_AXI_WRAP_EN: line fills use critical-word-first WRAP bursts.
module icache_axi_rd_bridge
   import icache_axi_pkg::*;
#(
   parameter int ID_W     = 4,
   parameter int ARID_VAL = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rd_req,
   input  logic [31:0]     rd_addr,
   input  logic [7:0]      rd_len,
   output logic            ret_valid,
   output logic [127:0]    ret_data,
   output logic            ret_err,
   output logic [ID_W-1:0] arid,
   output logic [31:0]     araddr,
   output logic [7:0]      arlen,
   output logic [2:0]      arsize,
   output logic [1:0]      arburst,
   output logic            arvalid,
   input  logic            arready,
   input  logic [ID_W-1:0] rid,
   input  logic [31:0]     rdata,
   input  logic [1:0]      rresp,
   input  logic            rlast,
   input  logic            rvalid,
   output logic            rready
);

   state_e      state_q, state_d;
   logic [31:0] araddr_q, araddr_d;
   logic [7:0]  arlen_q, arlen_d;
   logic [1:0]  arburst_q, arburst_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic        ret_valid_q, ret_valid_d;
   logic        clr, beat, is_line;
   logic [1:0]  start_lane;
   logic        unused_bits;

   assign unused_bits = ^{rid, rd_addr[1:0]};
   assign is_line     = (rd_len != UNC_LEN);

   assign arid      = ID_W'(ARID_VAL);
   assign arsize    = SIZE_4B;
   assign araddr    = araddr_q;
   assign arlen     = arlen_q;
   assign arburst   = arburst_q;
   assign arvalid   = arvalid_q;
   assign rready    = rready_q;
   assign ret_valid = ret_valid_q;

   // FSM next state and AR payload selection
   always_comb begin
      state_d     = state_q;
      araddr_d    = araddr_q;
      arlen_d     = arlen_q;
      arburst_d   = arburst_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      ret_valid_d = 1'b0;
      clr         = 1'b0;
      beat        = 1'b0;
      start_lane  = rd_addr[3:2];
      unique case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               clr       = 1'b1;
               arlen_d   = rd_len;
               arvalid_d = 1'b1;
               state_d   = ST_AR;
               if (is_line) begin
`ifdef ICACHE_AXI_WRAP_EN
                  araddr_d   = {rd_addr[31:2], 2'b00};
                  arburst_d  = BURST_WRAP;
                  start_lane = rd_addr[3:2];
`else
                  araddr_d   = {rd_addr[31:4], 4'h0};
                  arburst_d  = BURST_INCR;
                  start_lane = 2'd0;
`endif
               end else begin
                  araddr_d   = {rd_addr[31:2], 2'b00};
                  arburst_d  = BURST_INCR;
                  start_lane = rd_addr[3:2];
               end
            end
         end
         ST_AR: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_R;
            end
         end
         ST_R: begin
            if (rvalid) begin
               beat = 1'b1;
               if (rlast) begin
                  rready_d    = 1'b0;
                  ret_valid_d = 1'b1;
                  state_d     = ST_RET;
               end
            end
         end
         ST_RET: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and AR register slice
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         araddr_q    <= '0;
         arlen_q     <= '0;
         arburst_q   <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         ret_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         araddr_q    <= araddr_d;
         arlen_q     <= arlen_d;
         arburst_q   <= arburst_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         ret_valid_q <= ret_valid_d;
      end
   end

   icache_line_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .start_lane (start_lane),
      .beat       (beat),
      .rdata      (rdata),
      .rresp      (rresp),
      .line       (ret_data),
      .err        (ret_err)
   );

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Bench for icache_axi_rd_bridge: AXI slave stub plus line reference model.
// Directed cases from the test plan followed by randomized transactions.
module tb_icache_axi_rd_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic [7:0]   rd_len;
   logic         ret_valid;
   logic [127:0] ret_data;
   logic         ret_err;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic         arvalid;
   logic         arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;

   int checks = 0;
   int failures = 0;

   logic [31:0]  bd [8];
   logic [1:0]   br [8];
   logic [127:0] last_data;
   logic         last_err;

   always #5 clk = ~clk;

   icache_axi_rd_bridge #(.ID_W(4), .ARID_VAL(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_len    (rd_len),
      .ret_valid (ret_valid),
      .ret_data  (ret_data),
      .ret_err   (ret_err),
      .arid      (arid),
      .araddr    (araddr),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .arvalid   (arvalid),
      .arready   (arready),
      .rid       (rid),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rvalid    (rvalid),
      .rready    (rready)
   );

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rresp   = 2'b00;
      rdata   = 32'h0;
   endtask

   // One request end to end; called at #1 after a rising edge.
   task automatic txn(input logic [31:0] addr, input logic [7:0] len,
                      input int nb, input int aw, input int gap,
                      input bit drop);
      logic [31:0]  ea;
      logic [1:0]   eb;
      int           st;
      logic [127:0] el;
      logic         ee;
      int           exp_cyc, k, cyc, awc, gc;
      bit           fired, done;
      if (len != 8'd0) begin
`ifdef ICACHE_AXI_WRAP_EN
         ea = {addr[31:2], 2'b00};
         eb = 2'b10;
         st = int'(addr[3:2]);
`else
         ea = {addr[31:4], 4'h0};
         eb = 2'b01;
         st = 0;
`endif
      end else begin
         ea = {addr[31:2], 2'b00};
         eb = 2'b01;
         st = int'(addr[3:2]);
      end
      el = '0;
      ee = 1'b0;
      for (int i = 0; i < nb; i++) begin
         if (i < 4) el[32*((st+i)%4) +: 32] = bd[i];
         ee = ee | (br[i] != 2'b00);
      end
      exp_cyc = 3 + (nb - 1) + aw + gap * (nb - 1);

      rd_addr = addr;
      rd_len  = len;
      rd_req  = 1'b1;
      cyc = 0; k = 0; awc = aw; gc = 0;
      fired = 1'b0; done = 1'b0;
      while (!done && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         if (drop && cyc == 1) rd_req = 1'b0;
         if (fired) begin
            k++;
            gc = gap;
         end
         fired = 1'b0;
         idle_inputs();
         if (ret_valid) begin
            done = 1'b1;
         end else begin
            if (arvalid) begin
               chk("araddr", araddr, ea);
               chk("arlen", arlen, len);
               chk("arburst", arburst, eb);
               chk("arsize", arsize, 3'b010);
               chk("arid", arid, 4'h0);
               chk("rready_in_ar", rready, 1'b0);
               if (awc > 0) awc--;
               else arready = 1'b1;
            end
            if (rready && k < nb) begin
               if (gc > 0) gc--;
               else begin
                  rvalid = 1'b1;
                  rdata  = bd[k];
                  rresp  = br[k];
                  rlast  = (k == nb - 1);
                  fired  = 1'b1;
               end
            end
         end
      end
      if (!done) begin
         chk("ret_timeout", 1'b1, 1'b0);
      end else begin
         last_data = ret_data;
         last_err  = ret_err;
         chk("latency", cyc, exp_cyc);
         chk("ret_data", ret_data, el);
         chk("ret_err", ret_err, ee);
         chk("rready_in_ret", rready, 1'b0);
      end
      @(posedge clk); #1;
      chk("ret_single_pulse", ret_valid, 1'b0);
      chk("ret_ignores_req", arvalid, 1'b0);
      rd_req = 1'b0;
   endtask

   initial begin
      int nb;
      logic [7:0] len;
      rst = 1'b1;
      rd_req = 1'b0;
      rd_addr = 32'h0;
      rd_len = 8'h0;
      rid = 4'h0;
      idle_inputs();
      last_data = '0;
      last_err = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bd[i] = 32'h0;
         br[i] = 2'b00;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_arvalid", arvalid, 1'b0);
      chk("rst_rready", rready, 1'b0);
      chk("rst_ret_valid", ret_valid, 1'b0);
      chk("rst_ret_err", ret_err, 1'b0);
      chk("rst_ret_data", ret_data, 128'h0);
      chk("rst_araddr", araddr, 32'h0);
      chk("rst_arlen", arlen, 8'h0);
      chk("rst_arburst", arburst, 2'b00);
      rst = 1'b0;
      @(posedge clk); #1;

      bd[0] = 32'hA0; bd[1] = 32'hA1; bd[2] = 32'hA2; bd[3] = 32'hA3;
      txn(32'h1000_0024, 8'd3, 4, 0, 0, 1'b0);

      bd[0] = 32'hDEAD_BEEF;
      txn(32'h1FC0_0008, 8'd0, 1, 0, 0, 1'b0);
      chk("unc_lane2", last_data,
          128'h0000_0000_DEAD_BEEF_0000_0000_0000_0000);

      for (int i = 0; i < 4; i++) bd[i] = $urandom;
      txn(32'h0000_4440, 8'd3, 4, 5, 2, 1'b0);

      br[2] = 2'b10;
      txn(32'h0000_8000, 8'd3, 4, 0, 0, 1'b0);
      chk("err_flag_set", last_err, 1'b1);
      br[2] = 2'b00;
      txn(32'h0000_8010, 8'd3, 4, 0, 0, 1'b0);
      chk("err_flag_clear", last_err, 1'b0);

      for (int i = 0; i < 4; i++) bd[i] = $urandom;
      txn(32'h0000_9004, 8'd3, 4, 1, 1, 1'b1);

      for (int i = 0; i < 6; i++) bd[i] = $urandom;
      txn(32'h0000_A00C, 8'd3, 6, 0, 0, 1'b0);

      rd_addr = 32'h0000_B000;
      rd_len  = 8'd3;
      rd_req  = 1'b1;
      begin
         int w;
         w = 0;
         while (!rready && w < 20) begin
            @(posedge clk); #1;
            w++;
            arready = arvalid;
         end
         chk("rst_test_reach_r", rready, 1'b1);
      end
      arready = 1'b0;
      rvalid = 1'b1;
      rdata = 32'h1234_5678;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rd_req = 1'b0;
      idle_inputs();
      chk("midrst_arvalid", arvalid, 1'b0);
      chk("midrst_rready", rready, 1'b0);
      chk("midrst_ret_valid", ret_valid, 1'b0);
      for (int i = 0; i < 4; i++) bd[i] = $urandom;
      txn(32'h0000_C008, 8'd3, 4, 0, 0, 1'b0);

      bd[0] = 32'hB2; bd[1] = 32'hB3; bd[2] = 32'hB0; bd[3] = 32'hB1;
      txn(32'h2000_0038, 8'd3, 4, 0, 0, 1'b0);
`ifdef ICACHE_AXI_WRAP_EN
      chk("wrap_line", last_data, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
`endif

      for (int t = 0; t < 20; t++) begin
         len = ($urandom_range(0, 1) == 1) ? 8'd3 : 8'd0;
         nb = int'(len) + 1;
         for (int i = 0; i < 8; i++) begin
            bd[i] = $urandom;
            br[i] = ($urandom_range(0, 7) == 0) ?
                    2'($urandom_range(1, 3)) : 2'b00;
         end
         txn($urandom, len, nb, $urandom_range(0, 3),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
